// File: rtl/sh7604_mac_seq_pkg.sv
// rtl/sh7604_mac_seq_pkg.sv - shared types and constants for the MAC operand-fetch sequencer
package sh7604_mac_seq_pkg;

    typedef enum logic [2:0] {
        MAC_IDLE,
        MAC_RD1,
        MAC_FWD1,
        MAC_RD2,
        MAC_FWD2,
        MAC_FIN
    } mac_state_e;

    localparam logic [3:0] MACOP_MACL = 4'b1001;
    localparam logic [3:0] MACOP_MACW = 4'b1011;

    localparam logic [1:0] MAC_SEL_MA = 2'b01;
    localparam logic [1:0] MAC_SEL_MB = 2'b10;

    // Post-increment step for one operand.
    function automatic logic [31:0] mac_opsize(input logic is_long);
        return is_long ? 32'd4 : 32'd2;
    endfunction

endpackage

// File: rtl/sh7604_mac_seq.sv
// rtl/sh7604_mac_seq.sv - MAC.W/MAC.L @Rm+,@Rn+ operand fetch and multiplier load sequencer
module sh7604_mac_seq
    import sh7604_mac_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ce_r_i,
    input  logic        en_i,
    input  logic        cmd_req_i,
    input  logic        cmd_long_i,
    input  logic        cmd_s_i,
    input  logic        cmd_same_i,
    input  logic [31:0] cmd_rm_i,
    input  logic [31:0] cmd_rn_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rm_new_o,
    output logic [31:0] rn_new_o,
    output logic        mem_req_o,
    output logic [31:0] mem_a_o,
    output logic        mem_long_o,
    input  logic [31:0] mem_di_i,
    input  logic        mem_rdy_i,
    output logic [1:0]  mac_sel_o,
    output logic [3:0]  mac_op_o,
    output logic        mac_s_o,
    output logic        mac_we_o,
    output logic [31:0] mac_a_o,
    output logic [31:0] mac_di_o
);

    mac_state_e  state_q;
    logic        busy_q, done_q, mem_req_q, mem_long_q, mac_s_q, mac_we_q, same_q;
    logic [1:0]  mac_sel_q;
    logic [3:0]  mac_op_q;
    logic [31:0] mem_a_q, mac_a_q, mac_di_q, rm_new_q, rn_new_q, a1_q, a2_q;

    logic [31:0] cmd_sz_d, sz_d, a2_d, a1_inc_d, a2_inc_d;

    always_comb begin
        cmd_sz_d = mac_opsize(cmd_long_i);
        sz_d     = mac_opsize(mem_long_q);
        a2_d     = cmd_same_i ? (cmd_rn_i + cmd_sz_d) : cmd_rm_i;
        a1_inc_d = a1_q + sz_d;
        a2_inc_d = a2_q + sz_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= MAC_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_long_q <= 1'b0;
            mac_s_q    <= 1'b0;
            mac_we_q   <= 1'b0;
            same_q     <= 1'b0;
            mac_sel_q  <= 2'b00;
            mac_op_q   <= 4'b0000;
            mem_a_q    <= 32'd0;
            mac_a_q    <= 32'd0;
            mac_di_q   <= 32'd0;
            rm_new_q   <= 32'd0;
            rn_new_q   <= 32'd0;
            a1_q       <= 32'd0;
            a2_q       <= 32'd0;
        end else if (ce_r_i && en_i) begin
            done_q   <= 1'b0;
            mac_we_q <= 1'b0;
            case (state_q)
                MAC_IDLE: begin
                    if (cmd_req_i) begin
                        same_q     <= cmd_same_i;
                        a1_q       <= cmd_rn_i;
                        a2_q       <= a2_d;
                        mac_op_q   <= cmd_long_i ? MACOP_MACL : MACOP_MACW;
                        mac_s_q    <= cmd_s_i;
                        mem_long_q <= cmd_long_i;
                        mem_a_q    <= cmd_rn_i;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= MAC_RD1;
                    end
                end
                MAC_RD1: begin
                    if (mem_rdy_i) begin
                        mem_req_q <= 1'b0;
                        mac_we_q  <= 1'b1;
                        mac_sel_q <= MAC_SEL_MA;
                        mac_a_q   <= a1_q;
                        mac_di_q  <= mem_di_i;
                        state_q   <= MAC_FWD1;
                    end
                end
                MAC_FWD1: begin
                    mem_a_q   <= a2_q;
                    mem_req_q <= 1'b1;
                    state_q   <= MAC_RD2;
                end
                MAC_RD2: begin
                    if (mem_rdy_i) begin
                        mem_req_q <= 1'b0;
                        mac_we_q  <= 1'b1;
                        mac_sel_q <= MAC_SEL_MB;
                        mac_a_q   <= a2_q;
                        mac_di_q  <= mem_di_i;
                        state_q   <= MAC_FWD2;
                    end
                end
                MAC_FWD2: begin
                    state_q <= MAC_FIN;
                end
                MAC_FIN: begin
                    // For Rm==Rn, A2 is already Rn+SZ, so A2+SZ covers both writebacks.
                    rm_new_q <= a2_inc_d;
                    rn_new_q <= same_q ? a2_inc_d : a1_inc_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= MAC_IDLE;
                end
                default: state_q <= MAC_IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rm_new_o   = rm_new_q;
    assign rn_new_o   = rn_new_q;
    assign mem_req_o  = mem_req_q;
    assign mem_a_o    = mem_a_q;
    assign mem_long_o = mem_long_q;
    assign mac_sel_o  = mac_sel_q;
    assign mac_op_o   = mac_op_q;
    assign mac_s_o    = mac_s_q;
    assign mac_we_o   = mac_we_q;
    assign mac_a_o    = mac_a_q;
    assign mac_di_o   = mac_di_q;

endmodule

// File: tb/tb_sh7604_mac_seq.sv
// tb/tb_sh7604_mac_seq.sv - directed self-checking bench for sh7604_mac_seq
module tb_sh7604_mac_seq;

    localparam logic [31:0] DKEY = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst_n_i, ce_r_i, en_i, cmd_req_i, cmd_long_i, cmd_s_i, cmd_same_i;
    logic [31:0] cmd_rm_i, cmd_rn_i, mem_di_i;
    logic        mem_rdy_i;
    logic        busy_o, done_o, mem_req_o, mem_long_o, mac_s_o, mac_we_o;
    logic [31:0] rm_new_o, rn_new_o, mem_a_o, mac_a_o, mac_di_o;
    logic [1:0]  mac_sel_o;
    logic [3:0]  mac_op_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [1:0]  we_sel [8];
    logic [31:0] we_a   [8];
    logic [31:0] we_di  [8];
    logic [3:0]  we_op  [8];
    int          we_n = 0, we_consec = 0, stab_err = 0, wait_cnt = 0, delay_len = 0;
    logic [31:0] delay_addr = 32'hDEAD_BEEF;
    bit          prev_we = 0, prev_req = 0, prev_acc = 0;
    logic [31:0] prev_a = 32'd0;
    int          lat;

    always #5 clk = ~clk;

    assign mem_di_i = mem_a_o ^ DKEY;

    sh7604_mac_seq dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .ce_r_i(ce_r_i), .en_i(en_i),
        .cmd_req_i(cmd_req_i), .cmd_long_i(cmd_long_i), .cmd_s_i(cmd_s_i),
        .cmd_same_i(cmd_same_i), .cmd_rm_i(cmd_rm_i), .cmd_rn_i(cmd_rn_i),
        .busy_o(busy_o), .done_o(done_o), .rm_new_o(rm_new_o), .rn_new_o(rn_new_o),
        .mem_req_o(mem_req_o), .mem_a_o(mem_a_o), .mem_long_o(mem_long_o),
        .mem_di_i(mem_di_i), .mem_rdy_i(mem_rdy_i),
        .mac_sel_o(mac_sel_o), .mac_op_o(mac_op_o), .mac_s_o(mac_s_o),
        .mac_we_o(mac_we_o), .mac_a_o(mac_a_o), .mac_di_o(mac_di_o)
    );

    // Memory responder and multiplier-port monitor; inputs change #1 after posedge.
    always @(negedge clk) begin
        if (mem_req_o && prev_req && !prev_acc && mem_a_o !== prev_a) stab_err++;
        if (mem_req_o) begin
            mem_rdy_i = (mem_a_o != delay_addr) || (wait_cnt >= delay_len);
            if (en_i && ce_r_i) wait_cnt++;
        end else begin
            mem_rdy_i = 1'b0;
            wait_cnt  = 0;
        end
        prev_req = mem_req_o;
        prev_a   = mem_a_o;
        prev_acc = mem_rdy_i && en_i && ce_r_i;
        if (en_i && ce_r_i && rst_n_i) begin
            if (mac_we_o) begin
                if (prev_we) we_consec++;
                if (we_n < 8) begin
                    we_sel[we_n] = mac_sel_o;
                    we_a[we_n]   = mac_a_o;
                    we_di[we_n]  = mac_di_o;
                    we_op[we_n]  = mac_op_o;
                end
                we_n++;
                prev_we = 1;
            end else begin
                prev_we = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input bit lng, input bit s, input bit same,
                           input logic [31:0] rm, input logic [31:0] rn,
                           input int stall, input bit busy_req, output int l);
        we_n = 0; we_consec = 0; stab_err = 0; prev_we = 0;
        cmd_long_i = lng; cmd_s_i = s; cmd_same_i = same;
        cmd_rm_i = rm; cmd_rn_i = rn; cmd_req_i = 1'b1;
        @(posedge clk); #1;
        cmd_req_i = 1'b0;
        l = 1;
        chk("busy_rise", {31'd0, busy_o}, 32'd1);
        while (!done_o && l < 60) begin
            en_i = !(stall > 0 && l >= 1 && l < 1 + stall);
            if (busy_req) begin
                cmd_req_i = (l == 2 || l == 3);
                cmd_rn_i  = 32'hBAD0_0000;
                cmd_rm_i  = 32'hBAD1_0000;
            end
            @(posedge clk); #1;
            l++;
        end
        en_i = 1'b1;
        cmd_req_i = 1'b0;
    endtask

    task automatic check_cmd(input string t, input int l, input int l_exp, input bit lng, input bit s,
                             input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] rn_n, input logic [31:0] rm_n);
        logic [3:0] op;
        op = lng ? 4'b1001 : 4'b1011;
        chk({t, ".latency"}, l, l_exp);
        chk({t, ".done"}, {31'd0, done_o}, 32'd1);
        chk({t, ".busy_fall"}, {31'd0, busy_o}, 32'd0);
        chk({t, ".rn_new"}, rn_new_o, rn_n);
        chk({t, ".rm_new"}, rm_new_o, rm_n);
        chk({t, ".we_count"}, we_n, 32'd2);
        chk({t, ".we_consec"}, we_consec, 32'd0);
        chk({t, ".sel0"}, {30'd0, we_sel[0]}, 32'd1);
        chk({t, ".sel1"}, {30'd0, we_sel[1]}, 32'd2);
        chk({t, ".mac_a0"}, we_a[0], a1);
        chk({t, ".mac_a1"}, we_a[1], a2);
        chk({t, ".mac_di0"}, we_di[0], a1 ^ DKEY);
        chk({t, ".mac_di1"}, we_di[1], a2 ^ DKEY);
        chk({t, ".op0"}, {28'd0, we_op[0]}, {28'd0, op});
        chk({t, ".op1"}, {28'd0, we_op[1]}, {28'd0, op});
        chk({t, ".mac_s"}, {31'd0, mac_s_o}, {31'd0, s});
        chk({t, ".mem_long"}, {31'd0, mem_long_o}, {31'd0, lng});
        chk({t, ".addr_stable"}, stab_err, 32'd0);
        @(posedge clk); #1;
        chk({t, ".done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        rst_n_i = 1'b0; ce_r_i = 1'b1; en_i = 1'b1; cmd_req_i = 1'b0;
        cmd_long_i = 1'b0; cmd_s_i = 1'b0; cmd_same_i = 1'b0;
        cmd_rm_i = 32'd0; cmd_rn_i = 32'd0; mem_rdy_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy_o}, 32'd0);
        chk("rst.done", {31'd0, done_o}, 32'd0);
        chk("rst.mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst.mac_we", {31'd0, mac_we_o}, 32'd0);
        chk("rst.mac_sel", {30'd0, mac_sel_o}, 32'd0);
        chk("rst.mac_op", {28'd0, mac_op_o}, 32'd0);
        chk("rst.mem_a", mem_a_o, 32'd0);
        chk("rst.rn_new", rn_new_o, 32'd0);
        rst_n_i = 1'b1;
        @(posedge clk); #1;

        run_cmd(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_1000, 0, 1'b0, lat);
        check_cmd("macl", lat, 6, 1'b1, 1'b0, 32'h1000, 32'h2000, 32'h1004, 32'h2004);

        run_cmd(1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_3002, 0, 1'b0, lat);
        check_cmd("macw", lat, 6, 1'b0, 1'b1, 32'h3002, 32'h4000, 32'h3004, 32'h4002);

        run_cmd(1'b1, 1'b0, 1'b1, 32'h0000_7777, 32'h0000_5000, 0, 1'b0, lat);
        check_cmd("same", lat, 6, 1'b1, 1'b0, 32'h5000, 32'h5004, 32'h5008, 32'h5008);

        delay_addr = 32'h0000_1000; delay_len = 3;
        run_cmd(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0000_1000, 0, 1'b1, lat);
        check_cmd("delay", lat, 9, 1'b1, 1'b0, 32'h1000, 32'h2000, 32'h1004, 32'h2004);

        // Reset while the second read is outstanding.
        delay_addr = 32'h0000_6100; delay_len = 20;
        we_n = 0; prev_we = 0;
        cmd_long_i = 1'b1; cmd_s_i = 1'b1; cmd_same_i = 1'b0;
        cmd_rm_i = 32'h0000_6100; cmd_rn_i = 32'h0000_6000; cmd_req_i = 1'b1;
        @(posedge clk); #1;
        cmd_req_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!(mem_req_o && mem_a_o == 32'h0000_6100)) begin
                @(posedge clk); #1;
            end
        end
        chk("rst2.in_rd2", {31'd0, mem_req_o}, 32'd1);
        chk("rst2.we_before", we_n, 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst2.busy", {31'd0, busy_o}, 32'd0);
        chk("rst2.mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst2.mem_a", mem_a_o, 32'd0);
        chk("rst2.mac_we", {31'd0, mac_we_o}, 32'd0);
        chk("rst2.mac_sel", {30'd0, mac_sel_o}, 32'd0);
        chk("rst2.mac_op", {28'd0, mac_op_o}, 32'd0);
        chk("rst2.mac_s", {31'd0, mac_s_o}, 32'd0);
        chk("rst2.mac_a", mac_a_o, 32'd0);
        chk("rst2.mac_di", mac_di_o, 32'd0);
        chk("rst2.rm_new", rm_new_o, 32'd0);
        chk("rst2.rn_new", rn_new_o, 32'd0);
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        delay_len = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2.no_second_we", we_n, 32'd1);
        chk("rst2.idle_busy", {31'd0, busy_o}, 32'd0);
        chk("rst2.idle_req", {31'd0, mem_req_o}, 32'd0);

        run_cmd(1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0100, 0, 1'b0, lat);
        check_cmd("post_rst", lat, 6, 1'b0, 1'b0, 32'h0100, 32'h0200, 32'h0102, 32'h0202);

        run_cmd(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFFC, 2, 1'b0, lat);
        check_cmd("wrap_stall", lat, 8, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0100, 32'h0000_0000, 32'h0104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
